// File: rtl/alu_exec.sv
// alu_exec: 16-bit execute unit. Simple ops complete on the start edge;
// MUL/DIVU/REMU run a 16-step iterative engine and finish with a done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; simple ops complete on the accepting edge
// RUN   | iterative op in progress, one step per edge, count 0..15
module alu_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  aluOp,
  input  logic [15:0] rs1Value,
  input  logic [15:0] rs2Value,
  output logic [15:0] result,
  output logic        zeroFlag,
  output logic        carryFlag,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hB;
  localparam logic [3:0] OP_REMU = 4'hC;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic [3:0]  op_q;
  logic [15:0] a_q;    // MUL: shifting multiplicand; DIV: dividend in, quotient out
  logic [15:0] b_q;    // MUL: shifting multiplier;   DIV: divisor
  logic [15:0] acc_q;  // MUL: partial product;       DIV: partial remainder

  logic        accept;
  logic        finish;
  logic        is_iter;

  logic [15:0] simple_res;
  logic        simple_carry;
  logic        simple_zero;
  logic [16:0] sum17;

  logic [15:0] mul_acc_nxt;
  logic [16:0] rem_sh;
  logic [16:0] rem_diff;
  logic        sub_ok;
  logic [15:0] rem_nxt;
  logic [15:0] quo_nxt;
  logic [15:0] iter_res;

  assign is_iter = (aluOp == OP_MUL) || (aluOp == OP_DIVU) || (aluOp == OP_REMU);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && is_iter) state_nxt = RUN;
      RUN:  if (count == 4'd15)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and strobes
  always_comb begin
    busy   = (state == RUN);
    accept = (state == IDLE) && start;
    finish = (state == RUN) && (count == 4'd15);
  end

  // Single-cycle operations, evaluated straight from the live operands
  always_comb begin
    sum17        = {1'b0, rs1Value} + {1'b0, rs2Value};
    simple_res   = 16'h0000;
    simple_carry = 1'b0;
    case (aluOp)
      OP_ADD:  begin simple_res = sum17[15:0]; simple_carry = sum17[16]; end
      OP_SUB:  begin simple_res = rs1Value - rs2Value; simple_carry = (rs1Value < rs2Value); end
      OP_AND:  simple_res = rs1Value & rs2Value;
      OP_OR:   simple_res = rs1Value | rs2Value;
      OP_XOR:  simple_res = rs1Value ^ rs2Value;
      OP_SLL:  simple_res = rs1Value << rs2Value[3:0];
      OP_SRL:  simple_res = rs1Value >> rs2Value[3:0];
      OP_SRA:  simple_res = $unsigned($signed(rs1Value) >>> rs2Value[3:0]);
      OP_SLT:  simple_res = {15'd0, ($signed(rs1Value) < $signed(rs2Value))};
      OP_SLTU: simple_res = {15'd0, (rs1Value < rs2Value)};
      default: simple_res = 16'h0000;
    endcase
    // Reserved opcodes report all flags clear, including zero
    simple_zero = (aluOp <= OP_SLTU) && (simple_res == 16'h0000);
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_acc_nxt = acc_q + (b_q[0] ? a_q : 16'h0000);
    rem_sh      = {acc_q, a_q[15]};
    rem_diff    = rem_sh - {1'b0, b_q};
    sub_ok      = (rem_sh >= {1'b0, b_q});
    rem_nxt     = sub_ok ? rem_diff[15:0] : rem_sh[15:0];
    quo_nxt     = {a_q[14:0], sub_ok};
    case (op_q)
      OP_MUL:  iter_res = mul_acc_nxt;
      OP_DIVU: iter_res = quo_nxt;
      default: iter_res = rem_nxt;
    endcase
  end

  // Iteration datapath: operand latch on accept, one step per RUN edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 4'd0;
      op_q  <= 4'd0;
      a_q   <= 16'd0;
      b_q   <= 16'd0;
      acc_q <= 16'd0;
    end else if (accept) begin
      count <= 4'd0;
      op_q  <= aluOp;
      a_q   <= rs1Value;
      b_q   <= rs2Value;
      acc_q <= 16'd0;
    end else if (state == RUN) begin
      count <= count + 4'd1;
      if (op_q == OP_MUL) begin
        acc_q <= mul_acc_nxt;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
      end else begin
        acc_q <= rem_nxt;
        a_q   <= quo_nxt;
      end
    end
  end

  // Architected result, flags and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= 16'd0;
      zeroFlag  <= 1'b0;
      carryFlag <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (finish) begin
        result    <= iter_res;
        zeroFlag  <= (iter_res == 16'h0000);
        carryFlag <= 1'b0;
        done      <= 1'b1;
      end else if (accept && !is_iter) begin
        result    <= simple_res;
        zeroFlag  <= simple_zero;
        carryFlag <= simple_carry;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec. Expected results are queued
// when a start is issued and checked when done pulses.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  aluOp;
  logic [15:0] rs1Value;
  logic [15:0] rs2Value;
  logic [15:0] result;
  logic        zeroFlag;
  logic        carryFlag;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] res;
    logic        zf;
    logic        cf;
  } exp_t;

  exp_t sb_q[$];

  alu_exec dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluOp(aluOp),
    .rs1Value(rs1Value), .rs2Value(rs2Value), .result(result),
    .zeroFlag(zeroFlag), .carryFlag(carryFlag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [31:0] prod;
    logic [16:0] s;
    e.op = op; e.res = 16'h0; e.cf = 1'b0;
    case (op)
      4'h0: begin s = a + b; s = {1'b0, a} + {1'b0, b}; e.res = s[15:0]; e.cf = s[16]; end
      4'h1: begin e.res = a - b; e.cf = (a < b); end
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: e.res = a << b[3:0];
      4'h6: e.res = a >> b[3:0];
      4'h7: e.res = $unsigned($signed(a) >>> b[3:0]);
      4'h8: e.res = ($signed(a) < $signed(b)) ? 16'h1 : 16'h0;
      4'h9: e.res = (a < b) ? 16'h1 : 16'h0;
      4'hA: begin prod = {16'h0, a} * {16'h0, b}; e.res = prod[15:0]; end
      4'hB: e.res = (b == 0) ? 16'hFFFF : a / b;
      4'hC: e.res = (b == 0) ? a : a % b;
      default: e.res = 16'h0;
    endcase
    e.zf = (op <= 4'hC) && (e.res == 16'h0);
    return e;
  endfunction

  // Scoreboard: compare every done pulse against the oldest pending expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("res_op%0h", e.op), {16'h0, result}, {16'h0, e.res});
        chk($sformatf("zf_op%0h", e.op), {31'h0, zeroFlag}, {31'h0, e.zf});
        chk($sformatf("cf_op%0h", e.op), {31'h0, carryFlag}, {31'h0, e.cf});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    aluOp = op; rs1Value = a; rs2Value = b; start = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for completion of an iterative op issued just before; counts busy cycles
  task automatic wait_iter(input string tag, input int inject_at);
    int busy_cnt = 0;
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'd0);
      end else if (busy === 1'b1) begin
        busy_cnt++;
      end
      if (inject_at > 0 && i == inject_at) begin
        aluOp = 4'h0; rs1Value = 16'h5555; rs2Value = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, {31'h0, seen}, 32'd1);
    chk({tag, "_busy_cycles"}, busy_cnt, 32'd16);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    issue(op, a, b);
    if (op == 4'hA || op == 4'hB || op == 4'hC) wait_iter($sformatf("iter_op%0h", op), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; aluOp = 4'h0; rs1Value = 16'h0; rs2Value = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_zf", {31'h0, zeroFlag}, 32'h0);
    chk("rst_cf", {31'h0, carryFlag}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);

    // ADD wrap: done one cycle after start, width 1
    issue(4'h0, 16'hFFFF, 16'h0001);
    @(negedge clk);
    chk("add_done_hi", {31'h0, done}, 32'd1);
    @(negedge clk);
    chk("add_done_width", {31'h0, done}, 32'd0);

    // Back-to-back simple ops, one per cycle
    issue(4'h1, 16'h0003, 16'h0005);
    issue(4'h8, 16'h8000, 16'h0001);
    issue(4'h7, 16'h8000, 16'h0013);
    issue(4'h5, 16'h0001, 16'h000F);
    issue(4'h9, 16'h8000, 16'h0001);
    issue(4'h1, 16'h0005, 16'h0005);
    issue(4'hE, 16'h1234, 16'h5678);
    issue(4'h6, 16'h8000, 16'h0004);
    issue(4'h4, 16'hA5A5, 16'hFFFF);
    repeat (2) @(negedge clk);

    // MUL with an ignored start mid-run and operand changes in flight
    issue(4'hA, 16'h0123, 16'h0045);
    wait_iter("mul_inject", 5);
    chk("mul_result_hold", {16'h0, result}, 32'h4E6F);

    run_op(4'hB, 16'h0064, 16'h0007);
    run_op(4'hC, 16'h0064, 16'h0007);
    run_op(4'hB, 16'h1234, 16'h0000);
    run_op(4'hC, 16'h1234, 16'h0000);
    run_op(4'hB, 16'hFFFF, 16'h0001);
    run_op(4'hA, 16'hFFFF, 16'hFFFF);

    // Reset at iteration 8 of a MUL: aborted, no done, outputs cleared
    issue(4'hA, 16'h0123, 16'h0045);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    chk("abort_result", {16'h0, result}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    repeat (20) @(negedge clk);
    issue(4'h0, 16'h1000, 16'h0234);
    @(negedge clk);
    chk("post_abort_add_done", {31'h0, done}, 32'd1);

    // start held high re-issues each idle cycle
    @(negedge clk);
    aluOp = 4'h3; rs1Value = 16'h0F00; rs2Value = 16'h00F0; start = 1'b1;
    repeat (3) sb_q.push_back(model(4'h3, 16'h0F00, 16'h00F0));
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);

    // Random mix
    for (int i = 0; i < 30; i++) begin
      logic [3:0]  op;
      logic [15:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run_op(op, a, b);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
